// File: rtl/axi_w_burst_packer_if.sv
// AXI4 bus bundle shared by the initiator side and the crossbar-node side of the W burst packer.
// A zero user width still carries a 1-bit user field so every signal keeps a legal range.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 0
);
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int unsigned USER_WIDTH = (AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [USER_WIDTH-1:0]     aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic                      w_last;
  logic [USER_WIDTH-1:0]     w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [USER_WIDTH-1:0]     b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [USER_WIDTH-1:0]     ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [USER_WIDTH-1:0]     r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_w_burst_packer.sv
// Store-and-forward W buffer: AW is held until its burst (or a full FIFO) is local; AW/W appear N+1 cycles after AW accept.
// Input W stalls while the FIFO is full or the burst is complete; output W drains at master.w_ready pace. B/AR/R pass through.
module axi_w_burst_packer #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 0,
  parameter int unsigned BUFFER_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  AXI_BUS.slave                         slave,
  AXI_BUS.master                        master,
  output logic                          busy_o,
  output logic [$clog2(BUFFER_DEPTH):0] fill_o,
  output logic                          len_err_o
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned USER_W = (AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1;
  localparam int unsigned PTR_W  = $clog2(BUFFER_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic                      lock;
    logic [3:0]                cache;
    logic [2:0]                prot;
    logic [3:0]                qos;
    logic [3:0]                region;
    logic [USER_W-1:0]         user;
  } aw_t;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]         strb;
    logic [USER_W-1:0]         user;
  } w_beat_t;

  typedef enum logic [1:0] {IDLE, FILL, ISSUE, DRAIN} state_t;

  state_t            state;
  aw_t               aw_q;
  logic [8:0]        beats_total;
  logic [8:0]        in_cnt;
  logic [8:0]        out_cnt;
  logic              len_err;
  w_beat_t           mem [BUFFER_DEPTH];
  w_beat_t           beat_in;
  w_beat_t           beat_out;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fill;
  logic              full;
  logic              empty;
  logic              drain_phase;
  logic              push;
  logic              pop;
  logic              aw_in_hs;
  logic              aw_out_hs;
  logic              last_pop;

  assign full        = (fill == CNT_W'(BUFFER_DEPTH));
  assign empty       = (fill == '0);
  assign drain_phase = (state == ISSUE) || (state == DRAIN);

  assign slave.aw_ready = (state == IDLE) && !rst;
  // Full comes from the registered count, so a pop never opens the input in the same cycle.
  assign slave.w_ready  = !full && ((state == FILL) || (drain_phase && (in_cnt < beats_total)));

  assign beat_in  = '{data: slave.w_data, strb: slave.w_strb, user: slave.w_user};
  assign beat_out = mem[rd_ptr];

  assign master.aw_id     = aw_q.id;
  assign master.aw_addr   = aw_q.addr;
  assign master.aw_len    = aw_q.len;
  assign master.aw_size   = aw_q.size;
  assign master.aw_burst  = aw_q.burst;
  assign master.aw_lock   = aw_q.lock;
  assign master.aw_cache  = aw_q.cache;
  assign master.aw_prot   = aw_q.prot;
  assign master.aw_qos    = aw_q.qos;
  assign master.aw_region = aw_q.region;
  assign master.aw_user   = aw_q.user;
  assign master.aw_valid  = (state == ISSUE);

  assign master.w_data  = beat_out.data;
  assign master.w_strb  = beat_out.strb;
  assign master.w_user  = beat_out.user;
  assign master.w_valid = drain_phase && !empty;
  assign master.w_last  = (out_cnt == beats_total - 9'd1);

  assign push      = slave.w_valid && slave.w_ready;
  assign pop       = master.w_valid && master.w_ready;
  assign aw_in_hs  = slave.aw_valid && slave.aw_ready;
  assign aw_out_hs = master.aw_valid && master.aw_ready;
  assign last_pop  = pop && master.w_last;

  assign busy_o    = (state != IDLE);
  assign fill_o    = fill;
  assign len_err_o = len_err;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= beat_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      aw_q        <= '0;
      beats_total <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      len_err     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        in_cnt <= in_cnt + 9'd1;
        if (slave.w_last != (in_cnt == beats_total - 9'd1)) len_err <= 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        out_cnt <= out_cnt + 9'd1;
      end
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase

      case (state)
        IDLE: begin
          if (aw_in_hs) begin
            aw_q <= '{id: slave.aw_id, addr: slave.aw_addr, len: slave.aw_len,
                      size: slave.aw_size, burst: slave.aw_burst, lock: slave.aw_lock,
                      cache: slave.aw_cache, prot: slave.aw_prot, qos: slave.aw_qos,
                      region: slave.aw_region, user: slave.aw_user};
            beats_total <= {1'b0, slave.aw_len} + 9'd1;
            in_cnt      <= '0;
            out_cnt     <= '0;
            state       <= FILL;
          end
        end
        FILL: begin
          // Bursts longer than the FIFO cut through once it fills.
          if (push && ((in_cnt + 9'd1 == beats_total) || (fill == CNT_W'(BUFFER_DEPTH - 1))))
            state <= ISSUE;
        end
        ISSUE: begin
          // W may finish before AW is taken; then there is nothing left to drain.
          if (aw_out_hs) state <= (last_pop || (out_cnt == beats_total)) ? IDLE : DRAIN;
        end
        DRAIN: begin
          if (last_pop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign slave.b_id    = master.b_id;
  assign slave.b_resp  = master.b_resp;
  assign slave.b_user  = master.b_user;
  assign slave.b_valid = master.b_valid;
  assign master.b_ready = slave.b_ready;

  assign master.ar_id     = slave.ar_id;
  assign master.ar_addr   = slave.ar_addr;
  assign master.ar_len    = slave.ar_len;
  assign master.ar_size   = slave.ar_size;
  assign master.ar_burst  = slave.ar_burst;
  assign master.ar_lock   = slave.ar_lock;
  assign master.ar_cache  = slave.ar_cache;
  assign master.ar_prot   = slave.ar_prot;
  assign master.ar_qos    = slave.ar_qos;
  assign master.ar_region = slave.ar_region;
  assign master.ar_user   = slave.ar_user;
  assign master.ar_valid  = slave.ar_valid;
  assign slave.ar_ready   = master.ar_ready;

  assign slave.r_id    = master.r_id;
  assign slave.r_data  = master.r_data;
  assign slave.r_resp  = master.r_resp;
  assign slave.r_last  = master.r_last;
  assign slave.r_user  = master.r_user;
  assign slave.r_valid = master.r_valid;
  assign master.r_ready = slave.r_ready;
endmodule

// File: tb/tb_axi_w_burst_packer.sv
// Directed bench for axi_w_burst_packer: inputs change 1 time unit after posedge, outputs are checked at negedge.
module tb_axi_w_burst_packer;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [4:0] fill;
  logic       len_err;
  logic       exp_err;
  int         tests = 0;
  int         fails = 0;
  int         f_aw, f_in, f_w, mx;

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(0)) slv ();
  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(0)) mst ();

  axi_w_burst_packer #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(0), .BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .slave(slv), .master(mst),
    .busy_o(busy), .fill_o(fill), .len_err_o(len_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [7:0] len, input logic [31:0] addr);
    slv.aw_valid = 1'b1;
    slv.aw_len   = len;
    slv.aw_addr  = addr;
    @(negedge clk);
    chk("aw_ready_idle", slv.aw_ready, 1);
    next();
    slv.aw_valid = 1'b0;
  endtask

  // Streams n beats (base+i) into the slave side and checks the master side against the same sequence.
  task automatic burst(input int n, input logic [31:0] addr, input logic [31:0] base,
                       input int aw_stall, input bit w_tog, input int bad_idx,
                       output int first_aw_cyc, output int first_aw_in, output int first_w_cyc,
                       output int max_fill);
    int in_idx, out_idx, awv, aw_hs, cyc;
    bit s_hs, m_hs;
    in_idx = 0; out_idx = 0; awv = 0; aw_hs = 0; cyc = 0;
    first_aw_cyc = -1; first_aw_in = -1; first_w_cyc = -1; max_fill = 0;
    while (cyc < 400 && !(out_idx == n && aw_hs == 1)) begin
      slv.w_valid  = (in_idx < n);
      slv.w_data   = base + in_idx;
      slv.w_last   = (bad_idx >= 0) ? (in_idx == bad_idx) : (in_idx == n - 1);
      mst.aw_ready = (awv >= aw_stall);
      mst.w_ready  = w_tog ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      chk("len_err", len_err, exp_err);
      if (int'(fill) > max_fill) max_fill = int'(fill);
      if (fill == 5'(DEPTH)) chk("w_ready_when_full", slv.w_ready, 0);
      if (mst.w_valid && first_w_cyc < 0) first_w_cyc = cyc;
      if (mst.aw_valid) begin
        if (first_aw_cyc < 0) begin
          first_aw_cyc = cyc;
          first_aw_in  = in_idx;
        end
        chk("aw_addr_stable", mst.aw_addr, addr);
        chk("aw_len_stable", mst.aw_len, n - 1);
        awv++;
        if (mst.aw_ready) aw_hs++;
      end
      s_hs = slv.w_valid && slv.w_ready;
      m_hs = mst.w_valid && mst.w_ready;
      if (m_hs) begin
        chk("w_data", mst.w_data, base + out_idx);
        chk("w_last", mst.w_last, out_idx == n - 1);
      end
      if (s_hs && (slv.w_last != (in_idx == n - 1))) exp_err = 1'b1;
      next();
      if (s_hs) in_idx++;
      if (m_hs) out_idx++;
      cyc++;
    end
    chk("beats_accepted", in_idx, n);
    chk("beats_delivered", out_idx, n);
    chk("aw_issued_once", aw_hs, 1);
    slv.w_valid = 1'b0;
    @(negedge clk);
    chk("busy_after_burst", busy, 0);
    chk("aw_ready_after_burst", slv.aw_ready, 1);
    chk("mw_valid_after_burst", mst.w_valid, 0);
    chk("sw_ready_in_idle", slv.w_ready, 0);
    next();
  endtask

  initial begin
    rst = 1'b1;
    exp_err = 1'b0;
    slv.aw_id = 10'h2A; slv.aw_addr = '0; slv.aw_len = '0; slv.aw_size = 3'd2; slv.aw_burst = 2'd1;
    slv.aw_lock = 1'b0; slv.aw_cache = '0; slv.aw_prot = '0; slv.aw_qos = '0; slv.aw_region = '0;
    slv.aw_user = '0; slv.aw_valid = 1'b0;
    slv.w_data = '0; slv.w_strb = '1; slv.w_last = 1'b0; slv.w_user = '0; slv.w_valid = 1'b0;
    slv.b_ready = 1'b0;
    slv.ar_id = '0; slv.ar_addr = '0; slv.ar_len = '0; slv.ar_size = '0; slv.ar_burst = '0;
    slv.ar_lock = 1'b0; slv.ar_cache = '0; slv.ar_prot = '0; slv.ar_qos = '0; slv.ar_region = '0;
    slv.ar_user = '0; slv.ar_valid = 1'b0; slv.r_ready = 1'b0;
    mst.aw_ready = 1'b1; mst.w_ready = 1'b1;
    mst.b_id = '0; mst.b_resp = '0; mst.b_user = '0; mst.b_valid = 1'b0; mst.ar_ready = 1'b0;
    mst.r_id = '0; mst.r_data = '0; mst.r_resp = '0; mst.r_last = 1'b0; mst.r_user = '0;
    mst.r_valid = 1'b0;

    next();
    next();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_fill", fill, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_maw_valid", mst.aw_valid, 0);
    chk("rst_mw_valid", mst.w_valid, 0);
    chk("rst_sw_ready", slv.w_ready, 0);
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("aw_ready_after_rst", slv.aw_ready, 1);
    next();

    // Basic: 4 beats, AW and first W N+1 cycles after AW accept.
    send_aw(8'd3, 32'h1000);
    burst(4, 32'h1000, 32'hA0, 0, 1'b0, -1, f_aw, f_in, f_w, mx);
    chk("basic_aw_cycle", f_aw, 4);
    chk("basic_aw_after_beats", f_in, 4);
    chk("basic_w_cycle", f_w, 4);

    // Single beat: AW and W with w_last together.
    send_aw(8'd0, 32'h2000);
    burst(1, 32'h2000, 32'h55, 0, 1'b0, -1, f_aw, f_in, f_w, mx);
    chk("single_aw_cycle", f_aw, 1);
    chk("single_w_cycle", f_w, 1);

    // Cut-through: 32 beats through a 16-deep FIFO.
    send_aw(8'd31, 32'h3000);
    burst(32, 32'h3000, 32'h100, 0, 1'b0, -1, f_aw, f_in, f_w, mx);
    chk("cut_aw_after_16", f_in, 16);
    chk("cut_aw_cycle", f_aw, 16);
    chk("cut_max_fill", mx, 16);

    // Backpressure: AW held 10 cycles, W ready toggling.
    send_aw(8'd7, 32'h4000);
    burst(8, 32'h4000, 32'h200, 10, 1'b1, -1, f_aw, f_in, f_w, mx);
    chk("bp_aw_cycle", f_aw, 8);
    chk("bp_max_fill", mx, 8);

    // Length error: w_last on beat 2 only; still 4 beats out.
    send_aw(8'd3, 32'h4800);
    burst(4, 32'h4800, 32'h300, 0, 1'b0, 1, f_aw, f_in, f_w, mx);
    chk("len_err_sticky", len_err, 1);

    // Reset after 2 of 4 beats.
    send_aw(8'd3, 32'h5000);
    slv.w_valid = 1'b1; slv.w_data = 32'hB0; slv.w_last = 1'b0;
    next();
    slv.w_data = 32'hB1;
    next();
    slv.w_valid = 1'b0;
    rst = 1'b1;
    next();
    rst = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    chk("mid_rst_aw_ready", slv.aw_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fill", fill, 0);
    chk("mid_rst_len_err", len_err, 0);
    chk("mid_rst_maw_valid", mst.aw_valid, 0);
    next();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_no_aw", mst.aw_valid, 0);
      chk("mid_rst_no_w", mst.w_valid, 0);
      next();
    end

    // B/AR/R passthrough.
    mst.b_valid = 1'b1; mst.b_id = 10'h11; mst.b_resp = 2'd2;
    slv.b_ready = 1'b1; slv.ar_valid = 1'b1; slv.ar_addr = 32'hCAFE0000;
    mst.ar_ready = 1'b1; mst.r_valid = 1'b1; mst.r_data = 32'h12345678; slv.r_ready = 1'b1;
    @(negedge clk);
    chk("b_valid_pass", slv.b_valid, 1);
    chk("b_id_pass", slv.b_id, 10'h11);
    chk("b_resp_pass", slv.b_resp, 2'd2);
    chk("b_ready_pass", mst.b_ready, 1);
    chk("ar_addr_pass", mst.ar_addr, 32'hCAFE0000);
    chk("ar_ready_pass", slv.ar_ready, 1);
    chk("r_data_pass", slv.r_data, 32'h12345678);
    chk("r_ready_pass", mst.r_ready, 1);
    next();
    mst.b_valid = 1'b0; slv.b_ready = 1'b0; slv.ar_valid = 1'b0; mst.ar_ready = 1'b0;
    mst.r_valid = 1'b0; slv.r_ready = 1'b0;

    // Normal burst after the mid-fill reset.
    send_aw(8'd1, 32'h6000);
    burst(2, 32'h6000, 32'hC0, 0, 1'b0, -1, f_aw, f_in, f_w, mx);
    chk("post_rst_aw_cycle", f_aw, 2);
    chk("post_rst_len_err", len_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axi_w_burst_packer.md
Name: axi_w_burst_packer

Overview:
- Store-and-forward write-burst buffer placed directly upstream of each slave port of the AXI crossbar node.
- Holds an accepted AW until its whole W burst sits in a local FIFO, then issues AW and streams W back-to-back. A slow initiator therefore cannot hold the node's W routing while it dribbles data.
- B, AR and R pass through combinationally.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 32, data width. Strobe width is AXI_DATA_WIDTH/8.
- AXI_ID_WIDTH, 10, ID width, identical on both sides.
- AXI_USER_WIDTH, 0, user width.
- BUFFER_DEPTH, 16, W FIFO depth in beats. Power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- slave  AXI_BUS slave modport  -  from initiator / IO port.
- master  AXI_BUS master modport  -  to node slave port.
- busy_o  output  1  high whenever state != IDLE.
- fill_o  output  $clog2(BUFFER_DEPTH)+1  current FIFO occupancy.
- len_err_o  output  1  sticky: slave.w_last disagreed with AW length. Cleared only by rst.

Behaviour:
- Reset values (cycle after rst sampled high):
  - state=IDLE, FIFO empty, fill_o=0, busy_o=0, len_err_o=0.
  - master.aw_valid=0, master.w_valid=0, slave.w_ready=0.
  - slave.aw_ready=1 once rst is low.
- Reset mid-operation: FIFO contents and captured AW are discarded. An AW not yet issued is never issued. Downstream valids drop in the cycle after rst is sampled.
- States IDLE, FILL, ISSUE, DRAIN. Only one burst is in flight.
- IDLE:
  - slave.aw_ready=1, slave.w_ready=0.
  - On AW handshake: capture all AW fields, set beats_total = aw_len+1 (9-bit), in_cnt=0, out_cnt=0, go to FILL.
- FILL:
  - slave.w_ready = !full, where full is registered state, so there is no fall-through.
  - Each W handshake pushes {data, strb, user} and increments in_cnt.
  - Go to ISSUE when the pushed beat makes in_cnt==beats_total, or when the FIFO becomes full (cut-through for bursts longer than BUFFER_DEPTH).
- ISSUE:
  - master.aw_valid=1 with the captured payload, held stable until master.aw_ready.
  - master.w_valid = FIFO non-empty. W may precede the AW handshake.
  - On AW handshake go to DRAIN.
- ISSUE and DRAIN, input side: slave.w_ready = !full && in_cnt<beats_total.
- ISSUE and DRAIN, output side:
  - Each master W handshake pops one beat and increments out_cnt.
  - master.w_last = (out_cnt == beats_total-1). It is generated locally, never forwarded.
- DRAIN exit: go to IDLE on the handshake of the beat with master.w_last. The next AW can be accepted in the cycle after that.
- Push and pop in the same cycle: fill unchanged. Pointers wrap modulo BUFFER_DEPTH.
- len_err_o is set on any accepted slave W beat where slave.w_last != (in_cnt == beats_total-1). Regardless of the error, the block still accepts and forwards exactly beats_total beats.
- Slave W beats arriving in IDLE are not accepted (w_ready=0).
- Latency: AW handshake in cycle 0 and N<=BUFFER_DEPTH back-to-back W beats in cycles 1..N give master.aw_valid in cycle N+1. The first master W beat is also valid in cycle N+1.
- Passthrough, combinational, no state: slave↔master B, AR and R channels, all signals including ready.

Test Plan:
- Basic burst: AWLEN=3, addr 0x1000, W beats 0xA0..0xA3 back-to-back, master readies tied 1 -> master AW in cycle 5; W 0xA0..0xA3 in cycles 5..8, w_last only on 0xA3; slave.aw_ready=1 again in cycle 9; len_err_o=0.
- Single beat: AWLEN=0, one W beat 0x55 -> master AW and W together in cycle 2 with w_last=1; busy_o low from cycle 3.
- Cut-through: AWLEN=31 with BUFFER_DEPTH=16 -> master AW after 16 beats buffered; fill_o never exceeds 16; all 32 beats delivered in order; w_last only on beat 32.
- Backpressure: AWLEN=7, master.aw_ready=0 for 10 cycles and master.w_ready toggling 1/0 -> AW payload stable while valid; no beat lost or duplicated; slave.w_ready=0 whenever fill_o=BUFFER_DEPTH.
- Length error: AWLEN=3, slave asserts w_last on beat 2 and not on beat 4 -> len_err_o=1 from cycle after beat 2 and stays set; master still receives 4 beats with w_last on the 4th.
- Reset mid-FILL: rst pulsed after 2 of 4 beats -> no master AW ever issued; fill_o=0, busy_o=0; slave.aw_ready=1 the first cycle rst is low; a following AWLEN=1 burst completes normally.
